// File: rtl/ram_responder.sv
// ============================================================================
// Module  : ram_responder
// Brief   : Word-addressed RAM behind the CPU byte-address port, with a
//           post-reset zeroing sweep and illegal-access flagging.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_responder #(
    parameter int DEPTH_LOG2     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] CNT_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] CNT_MAX = {DEPTH_LOG2{1'b1}};

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;

    logic [31:0]           mem [0:DEPTH-1];

    state_t                state;
    state_t                state_next;
    logic [DEPTH_LOG2-1:0] cnt;
    logic [DEPTH_LOG2-1:0] cnt_next;
    logic [31:0]           data_next;
    logic                  err_next;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    logic [DEPTH_LOG2-1:0] idx;
    logic                  legal;

    assign idx    = addr_i[DEPTH_LOG2+1:2];
    assign legal  = (addr_i[1:0] == 2'b00) && (addr_i[31:DEPTH_LOG2+2] == '0);
    assign busy_o = (state == S_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RESET_STATE;
            cnt    <= '0;
            data_o <= '0;
            err_o  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            data_o <= data_next;
            err_o  <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        data_next  = '0;
        err_next   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = idx;
        mem_wdata  = data_i;

        case (state)
            S_CLEAR: begin
                // CPU inputs are ignored; the sweep owns the write port.
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
                cnt_next  = cnt + CNT_ONE;
                if (cnt == CNT_MAX) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                if (!legal) begin
                    err_next = 1'b1;
                end else if (we_i) begin
                    mem_we    = 1'b1;
                    data_next = data_i;
                end else begin
                    data_next = mem[idx];
                end
            end
        endcase
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ============================================================================
// Module  : tb_ram_responder
// Brief   : Self-checking bench for ram_responder against a word-array model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_responder;

    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] data_o;
    logic        busy_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    // Reference model: plain word array, busy countdown after reset release.
    logic [31:0] ref_mem [0:WORDS-1];
    int          busy_left = WORDS;
    logic [31:0] exp_data = '0;
    logic        exp_err = 1'b0;

    ram_responder #(
        .DEPTH_LOG2     (10),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .we_i   (we),
        .addr_i (addr),
        .data_i (wdata),
        .data_o (data_o),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_data = '0;
        exp_err  = 1'b0;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
            end
        end else if (a[1:0] != 2'b00 || a >= 32'(WORDS * 4)) begin
            exp_err = 1'b1;
        end else if (w) begin
            ref_mem[a / 4] = d;
            exp_data       = d;
        end else begin
            exp_data = ref_mem[a / 4];
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare #1 later.
    task automatic step(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        check({tag, ".data"}, data_o, exp_data);
        check({tag, ".err"}, {31'b0, err_o}, {31'b0, exp_err});
        check({tag, ".busy"}, {31'b0, busy_o}, {31'b0, (busy_left > 0)});
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, ".rst_data"}, data_o, 32'h0);
        check({tag, ".rst_err"}, {31'b0, err_o}, 32'h0);
        check({tag, ".rst_busy"}, {31'b0, busy_o}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".rst_hold_busy"}, {31'b0, busy_o}, 32'h1);
        reset     = 1'b0;
        busy_left = WORDS;
    endtask

    task automatic sweep_garbage(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'($urandom), $urandom_range(0, 32'hFFC) & 32'hFFFF_FFFC, $urandom);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          kind;

        // Test 1: sweep with CPU write noise, then every word reads zero.
        @(posedge clk);
        #1;
        do_reset("t1");
        sweep_garbage("t1.sweep", WORDS);
        for (int i = 0; i < WORDS; i++) begin
            step("t1.read", 1'b0, 32'(i * 4), $urandom);
        end

        // Test 2: write then read back, write-first on data_o.
        step("t2.wr", 1'b1, 32'h10, 32'hDEAD_BEEF);
        step("t2.rd", 1'b0, 32'h10, 32'h0);

        // Test 3: misaligned write is dropped and flagged.
        step("t3.mis", 1'b1, 32'h3, 32'h1234_5678);
        step("t3.rd0", 1'b0, 32'h0, 32'h0);

        // Test 4: first word past the array, no aliasing onto word 0.
        step("t4.oor", 1'b0, 32'h1000, 32'h0);
        step("t4.oorw", 1'b1, 32'h1000, 32'hFFFF_FFFF);
        step("t4.rd0", 1'b0, 32'h0, 32'h0);

        // Test 6: streaming write/write/read/read.
        step("t6.w1", 1'b1, 32'h8, 32'h1);
        step("t6.w2", 1'b1, 32'h8, 32'h2);
        step("t6.r8", 1'b0, 32'h8, 32'h0);
        step("t6.rC", 1'b0, 32'hC, 32'h0);

        // Test 5: reset lands mid-sweep; the sweep restarts from scratch.
        step("t5.wr", 1'b1, 32'h4, 32'hA5A5_A5A5);
        step("t5.rd", 1'b0, 32'h4, 32'h0);
        do_reset("t5a");
        sweep_garbage("t5.part", 500);
        do_reset("t5b");
        sweep_garbage("t5.sweep", WORDS);
        step("t5.rd4", 1'b0, 32'h4, 32'h0);

        // Randomised traffic in a small window plus occasional illegal addresses.
        for (int i = 0; i < 2000; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                a = ($urandom_range(0, 32'hFFF) & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            end else if (kind == 1) begin
                a = $urandom | (32'h1 << $urandom_range(12, 31));
            end else if (kind == 2) begin
                a = $urandom_range(0, 32'hFFF) & 32'hFFFF_FFFC;
            end else begin
                a = 32'($urandom_range(0, 15) * 4);
            end
            step("rnd", 1'($urandom), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
